// File: rtl/mmcm_reset_sequencer_pkg.sv
// Shared definitions for the MMCM reset sequencer: state encodings and a
// helper used to size the shared timer.
package mmcm_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_MMCM_RST  = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mmcm_reset_sequencer_sync.sv
// N-stage flop synchronizer for a single asynchronous bit; resets to 0.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// Sequences MMCM reset, qualifies lock for a stability window and releases the
// design-wide reset; retries on lock timeout and re-sequences on lock loss.
module mmcm_reset_sequencer
    import mmcm_reset_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = 3,
    parameter int unsigned MMCM_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_WIDTH           = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mmcm_locked,
    output logic                 mmcm_rst,
    output logic                 rst_out,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] retry_count,
    output logic [CNT_WIDTH-1:0] lock_loss_count,
    output logic [1:0]           state
);

    localparam int unsigned TMR_W =
        $clog2(max3(MMCM_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES) + 1);

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(MMCM_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic                 w_locked_s;
    state_t               r_state;
    state_t               w_next;
    logic [TMR_W-1:0]     r_timer;
    logic [TMR_W-1:0]     w_timer_next;
    logic                 w_retry_inc;
    logic                 w_loss_inc;
    logic                 r_mmcm_rst;
    logic                 r_rst_out;
    logic                 r_ready;
    logic [CNT_WIDTH-1:0] r_retry;
    logic [CNT_WIDTH-1:0] r_loss;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (mmcm_locked),
        .o_q   (w_locked_s)
    );

    // Timer counts elapsed cycles in the current state and is cleared on every
    // state entry, so its reset value of 0 also starts the first reset pulse.
    always_comb begin
        w_next       = r_state;
        w_retry_inc  = 1'b0;
        w_loss_inc   = 1'b0;
        w_timer_next = (r_timer == '1) ? r_timer : r_timer + 1'b1;

        unique case (r_state)
            S_MMCM_RST: begin
                if (r_timer == RST_LAST) begin
                    w_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next = S_STABLE;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_next      = S_MMCM_RST;
                    w_retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                if (!w_locked_s) begin
                    w_next = S_WAIT_LOCK;
                end else if (r_timer == STABLE_LAST) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_next     = S_MMCM_RST;
                    w_loss_inc = 1'b1;
                end
            end
        endcase

        if (w_next != r_state) begin
            w_timer_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_MMCM_RST;
            r_timer    <= '0;
            r_mmcm_rst <= 1'b1;
            r_rst_out  <= 1'b1;
            r_ready    <= 1'b0;
            r_retry    <= '0;
            r_loss     <= '0;
        end else begin
            r_state    <= w_next;
            r_timer    <= w_timer_next;
            r_mmcm_rst <= (w_next == S_MMCM_RST);
            r_rst_out  <= (w_next != S_RUN);
            r_ready    <= (w_next == S_RUN);
            if (w_retry_inc && (r_retry != '1)) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_loss_inc && (r_loss != '1)) begin
                r_loss <= r_loss + 1'b1;
            end
        end
    end

    assign mmcm_rst        = r_mmcm_rst;
    assign rst_out         = r_rst_out;
    assign ready           = r_ready;
    assign retry_count     = r_retry;
    assign lock_loss_count = r_loss;
    assign state           = r_state;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Scoreboard bench for mmcm_reset_sequencer: stimulus queues cycle-tagged
// expected snapshots, a negedge monitor pops and compares them.
module tb_mmcm_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       lock_a;
    logic       mrst_a, rout_a, rdy_a;
    logic [7:0] retry_a, loss_a;
    logic [1:0] st_a;

    logic       rst_n_b;
    logic       lock_b;
    logic       mrst_b, rout_b, rdy_b;
    logic [1:0] retry_b, loss_b;
    logic [1:0] st_b;

    int cyc;
    int n_vec;
    int n_bad;

    typedef struct {
        int         cyc;
        int         dut;
        string      name;
        logic       mrst;
        logic       rout;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] retry;
        logic [7:0] loss;
    } exp_t;

    exp_t sb[$];

    mmcm_reset_sequencer #(
        .SYNC_STAGES         (2),
        .MMCM_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (20),
        .CNT_WIDTH           (8)
    ) u_dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .mmcm_locked     (lock_a),
        .mmcm_rst        (mrst_a),
        .rst_out         (rout_a),
        .ready           (rdy_a),
        .retry_count     (retry_a),
        .lock_loss_count (loss_a),
        .state           (st_a)
    );

    mmcm_reset_sequencer #(
        .SYNC_STAGES         (2),
        .MMCM_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (20),
        .CNT_WIDTH           (2)
    ) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_n_b),
        .mmcm_locked     (lock_b),
        .mmcm_rst        (mrst_b),
        .rst_out         (rout_b),
        .ready           (rdy_b),
        .retry_count     (retry_b),
        .lock_loss_count (loss_b),
        .state           (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input int dut, input int c, input string name,
                                input logic mrst, input logic rout, input logic rdy,
                                input logic [1:0] st, input logic [7:0] retry,
                                input logic [7:0] loss);
        exp_t e;
        e.cyc = c; e.dut = dut; e.name = name;
        e.mrst = mrst; e.rout = rout; e.rdy = rdy;
        e.st = st; e.retry = retry; e.loss = loss;
        return e;
    endfunction

    task automatic push(input int dut, input int c, input string name,
                        input logic mrst, input logic rout, input logic rdy,
                        input logic [1:0] st, input logic [7:0] retry,
                        input logic [7:0] loss);
        sb.push_back(mk(dut, c, name, mrst, rout, rdy, st, retry, loss));
    endtask

    function automatic exp_t sample(input int dut);
        exp_t a;
        a.cyc = cyc; a.dut = dut; a.name = "";
        if (dut == 0) begin
            a.mrst = mrst_a; a.rout = rout_a; a.rdy = rdy_a;
            a.st = st_a; a.retry = retry_a; a.loss = loss_a;
        end else begin
            a.mrst = mrst_b; a.rout = rout_b; a.rdy = rdy_b;
            a.st = st_b; a.retry = {6'd0, retry_b}; a.loss = {6'd0, loss_b};
        end
        return a;
    endfunction

    task automatic check(input exp_t e, input exp_t a);
        n_vec++;
        if ({a.mrst, a.rout, a.rdy, a.st, a.retry, a.loss} !==
            {e.mrst, e.rout, e.rdy, e.st, e.retry, e.loss}) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d got mrst=%b rout=%b rdy=%b st=%0d retry=%0d loss=%0d expected mrst=%b rout=%b rdy=%b st=%0d retry=%0d loss=%0d",
                     e.name, e.dut, e.cyc, a.mrst, a.rout, a.rdy, a.st, a.retry, a.loss,
                     e.mrst, e.rout, e.rdy, e.st, e.retry, e.loss);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s missed: sampled at cyc=%0d, required cyc=%0d", e.name, cyc, e.cyc);
            end else begin
                check(e, sample(e.dut));
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int b, c0, c1, c2, b2, b3;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0; rst_n_b = 1'b0;
        lock_a = 1'b0; lock_b = 1'b0;

        push(0, 2, "reset_state", 1, 1, 0, 0, 0, 0);
        wait_until(3);
        rst_n = 1'b1;
        b = 3;

        // Nominal bring-up, lock raised before edge 10
        push(0, b+1,  "mrst_edge1",   1, 1, 0, 0, 0, 0);
        push(0, b+3,  "mrst_edge3",   1, 1, 0, 0, 0, 0);
        push(0, b+4,  "wait_entry",   0, 1, 0, 1, 0, 0);
        push(0, b+11, "lock_in_sync", 0, 1, 0, 1, 0, 0);
        push(0, b+12, "stable_entry", 0, 1, 0, 2, 0, 0);
        push(0, b+19, "stable_last",  0, 1, 0, 2, 0, 0);
        push(0, b+20, "run_entry",    0, 0, 1, 3, 0, 0);
        wait_until(b+9);
        lock_a = 1'b1;

        // Lock loss in run and re-sequence
        c0 = b + 25;
        wait_until(c0);
        lock_a = 1'b0;
        push(0, c0+2,  "run_hold",      0, 0, 1, 3, 0, 0);
        push(0, c0+3,  "loss_reset",    1, 1, 0, 0, 0, 1);
        push(0, c0+7,  "loss_wait",     0, 1, 0, 1, 0, 1);
        push(0, c0+19, "loss_stable",   0, 1, 0, 2, 0, 1);
        push(0, c0+20, "loss_rerun",    0, 0, 1, 3, 0, 1);
        wait_until(c0+9);
        lock_a = 1'b1;

        // Stability abort with the drop landing on the final window cycle
        c1 = c0 + 25;
        wait_until(c1);
        lock_a = 1'b0;
        push(0, c1+3,  "abort_loss",     1, 1, 0, 0, 0, 2);
        push(0, c1+19, "abort_pre_last", 0, 1, 0, 2, 0, 2);
        push(0, c1+20, "final_drop",     0, 1, 0, 1, 0, 2);
        push(0, c1+22, "abort_waiting",  0, 1, 0, 1, 0, 2);
        push(0, c1+23, "restable",       0, 1, 0, 2, 0, 2);
        push(0, c1+30, "window_restart", 0, 1, 0, 2, 0, 2);
        push(0, c1+31, "abort_run",      0, 0, 1, 3, 0, 2);
        wait_until(c1+9);
        lock_a = 1'b1;
        wait_until(c1+17);
        lock_a = 1'b0;
        wait_until(c1+20);
        lock_a = 1'b1;

        // Timeout retries, then lock coinciding with expiry
        c2 = c1 + 35;
        wait_until(c2);
        lock_a = 1'b0;
        push(0, c2+3,  "to_loss",        1, 1, 0, 0, 0, 3);
        push(0, c2+26, "to_wait_last",   0, 1, 0, 1, 0, 3);
        push(0, c2+27, "timeout1",       1, 1, 0, 0, 1, 3);
        push(0, c2+30, "retry_pulse",    1, 1, 0, 0, 1, 3);
        push(0, c2+31, "retry_wait",     0, 1, 0, 1, 1, 3);
        push(0, c2+51, "timeout2",       1, 1, 0, 0, 2, 3);
        push(0, c2+74, "expiry_pending", 0, 1, 0, 1, 2, 3);
        push(0, c2+75, "lock_vs_expiry", 0, 1, 0, 2, 2, 3);
        wait_until(c2+72);
        lock_a = 1'b1;

        // Asynchronous reset between edges while in stable
        wait_until(c2+78);
        #2 rst_n = 1'b0;
        #1 check(mk(0, cyc, "async_reset", 1, 1, 0, 0, 0, 0), sample(0));
        wait_until(c2+80);
        rst_n = 1'b1;
        b2 = c2 + 80;
        push(0, b2+3,  "post_rst_mrst",   1, 1, 0, 0, 0, 0);
        push(0, b2+4,  "post_rst_wait",   0, 1, 0, 1, 0, 0);
        push(0, b2+5,  "post_rst_stable", 0, 1, 0, 2, 0, 0);
        push(0, b2+13, "post_rst_run",    0, 0, 1, 3, 0, 0);

        // Saturation of a 2-bit retry counter
        b3 = b2 + 20;
        wait_until(b3);
        rst_n_b = 1'b1;
        push(1, b3+24,  "sat_retry1", 1, 1, 0, 0, 1, 0);
        push(1, b3+48,  "sat_retry2", 1, 1, 0, 0, 2, 0);
        push(1, b3+72,  "sat_reach",  1, 1, 0, 0, 3, 0);
        push(1, b3+96,  "sat_hold4",  1, 1, 0, 0, 3, 0);
        push(1, b3+100, "sat_wait",   0, 1, 0, 1, 3, 0);
        push(1, b3+120, "sat_hold5",  1, 1, 0, 0, 3, 0);
        wait_until(b3+125);

        repeat (10) begin
            if (sb.size() > 0) @(negedge clk);
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s never sampled: required cyc=%0d, run ended at cyc=%0d", e.name, e.cyc, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #50000;
        n_bad++;
        $display("FAIL watchdog expired at cyc=%0d with %0d checks pending", cyc, sb.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
